matriz_determ3x3_seq: RTL
=========================

MATRIZ_DETERM3X3_SEQ -- requirements
Module: matriz_determ3x3_seq

Interface
Parameters: none.
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 matrix  input  200  packed matrix in 5x5 grid layout; element (r,c) at bits [r*40 + c*8 +: 8]; only r,c in 0..2 used, other bits ignored.
REQ-005 start  input  1  level request from the initiator; held high until the result is consumed; low means abort or release.
REQ-006 done  output  1  result valid; held high while start stays high.
REQ-007 det  output  8  determinant of the 3x3 submatrix, two's complement, modulo 256.
REQ-008 busy  output  1  high while terms are being accumulated.

Function
REQ-009 The block SHALL be the responder side of the level start/done handshake used by the determinant cascade: a single result per start assertion; done goes 0->1 once and only once per start assertion.
REQ-010 States SHALL be IDLE, TERM, DONE.
REQ-011 IDLE: done=0, busy=0; if start=1 at a clock edge -> capture all 9 elements into internal registers, clear accumulator, term counter k=0, go to TERM.
REQ-012 TERM: busy=1; each edge adds or subtracts term k and increments k; k runs 0..5; at the edge processing k=5 -> det<=final sum, done<=1, go to DONE.
REQ-013 Term order SHALL be: k0 +a00*a11*a22, k1 +a01*a12*a20, k2 +a02*a10*a21, k3 -a02*a11*a20, k4 -a00*a12*a21, k5 -a01*a10*a22.
REQ-014 Arithmetic SHALL be unsigned 8-bit elements, products and accumulator truncated to 8 bits (mod 256) at every step; no saturation, no overflow flag.
REQ-015 Latency SHALL be exactly 7 rising edges from the edge that samples start=1 in IDLE to the edge that sets done=1.
REQ-016 DONE: done=1, busy=0, det stable; stays while start=1; start=0 -> next edge done<=0, det<=0, go to IDLE.
REQ-017 start=0 in TERM SHALL abort: next edge -> IDLE, accumulator discarded, done=0, det=0; done never pulses for an aborted run.
REQ-018 Changes on matrix after the capture edge SHALL NOT affect the result of the current run.
REQ-019 det SHALL only change on the edge entering DONE or on leaving DONE/aborting (to 0); det never shows partial sums.
REQ-020 start held high continuously after done SHALL NOT start a second computation; a new run requires start to return low for at least one edge.

Reset
REQ-021 rst_n=0 SHALL immediately, without a clock, force state=IDLE, done=0, busy=0, det=0, k=0, accumulator=0.
REQ-022 Reset asserted mid-TERM or in DONE SHALL discard the run; after release with start=1 a fresh run begins on the first edge.
REQ-023 Release of rst_n SHALL be synchronous-safe: no state change on the edge coincident with release other than normal IDLE sampling.

Verification
REQ-024 Identity (a00=a11=a22=1, others 0), start=1 -> done=1 on edge 7, det=8'h01, busy high for edges 2..7 only.
REQ-025 Rows {1,2,3},{4,5,6},{7,8,9} -> det=8'h00; diag {2,3,4} -> det=8'h18; rows {0,1,0},{1,0,0},{0,0,1} -> det=8'hFF.
REQ-026 Wrap: diag {10,10,3} -> det=8'h2C (300 mod 256); matrix changed to all-zero on edge 3 -> result still 8'h2C.
REQ-027 Abort: start dropped after edge 3 -> next edge done=0, det=0, IDLE; start raised again with diag {2,3,4} -> det=8'h18 after 7 edges, no earlier done pulse.
REQ-028 Async reset mid-TERM (between edges) -> outputs 0 immediately; start held high in DONE for 20 cycles -> done stays 1, single done rising edge, det constant.

Source files
------------

// File: rtl/matriz_determ3x3_seq.sv
// Sequential 3x3 determinant (mod 256), one product term per clock; result 7 edges after start capture.
// Level start/done responder: done holds while start stays high, start low aborts or releases.
module matriz_determ3x3_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [199:0] matrix,
  input  logic         start,
  output logic         done,
  output logic [7:0]   det,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, TERM, DONE} state_t;

  state_t     state;
  logic [2:0] k;
  logic [7:0] acc;
  logic [7:0] el [3][3];

  logic [7:0] fx, fy, fz;
  logic [7:0] xy, prod;
  logic       sub;
  logic [7:0] acc_nxt;

  // Operand selection for term k; terms 3..5 are the subtracted diagonals.
  always_comb begin
    fx  = 8'd0;
    fy  = 8'd0;
    fz  = 8'd0;
    sub = 1'b0;
    case (k)
      3'd0: begin fx = el[0][0]; fy = el[1][1]; fz = el[2][2]; end
      3'd1: begin fx = el[0][1]; fy = el[1][2]; fz = el[2][0]; end
      3'd2: begin fx = el[0][2]; fy = el[1][0]; fz = el[2][1]; end
      3'd3: begin fx = el[0][2]; fy = el[1][1]; fz = el[2][0]; sub = 1'b1; end
      3'd4: begin fx = el[0][0]; fy = el[1][2]; fz = el[2][1]; sub = 1'b1; end
      3'd5: begin fx = el[0][1]; fy = el[1][0]; fz = el[2][2]; sub = 1'b1; end
      default: begin fx = 8'd0; fy = 8'd0; fz = 8'd0; sub = 1'b0; end
    endcase
  end

  assign xy      = fx * fy;
  assign prod    = xy * fz;
  assign acc_nxt = sub ? (acc - prod) : (acc + prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= 3'd0;
      acc   <= 8'd0;
      done  <= 1'b0;
      busy  <= 1'b0;
      det   <= 8'd0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          el[r][c] <= 8'd0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          det  <= 8'd0;
          if (start) begin
            for (int r = 0; r < 3; r++) begin
              for (int c = 0; c < 3; c++) begin
                el[r][c] <= matrix[r*40 + c*8 +: 8];
              end
            end
            acc   <= 8'd0;
            k     <= 3'd0;
            busy  <= 1'b1;
            state <= TERM;
          end
        end
        TERM: begin
          if (!start) begin
            acc   <= 8'd0;
            k     <= 3'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            det   <= 8'd0;
            state <= IDLE;
          end else if (k == 3'd5) begin
            det   <= acc_nxt;
            acc   <= acc_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            k     <= 3'd0;
            state <= DONE;
          end else begin
            acc <= acc_nxt;
            k   <= k + 3'd1;
          end
        end
        DONE: begin
          // Holding start high keeps the result; a new run needs start low first.
          if (!start) begin
            done  <= 1'b0;
            det   <= 8'd0;
            acc   <= 8'd0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          k     <= 3'd0;
          acc   <= 8'd0;
          done  <= 1'b0;
          busy  <= 1'b0;
          det   <= 8'd0;
        end
      endcase
    end
  end

endmodule
